// File: rtl/uart_command_serializer.sv
// rtl/uart_command_serializer.sv - streams a latched command buffer plus link terminator to a UART TX core
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            request to send, sampled only while idle
//   input_data       payload, byte k at [8k+7:8k], byte 0 sent first
//   input_data_size  payload length in bytes (1..MAX_BYTES accepted)
//   ble_side         1: terminator 0x0D, 0: terminator 0xBE 0xEF
//   abort            drops an in-flight send on the next edge
//   tx_ready         UART TX accepts tx_data this cycle
//   tx_data          byte offered to UART TX
//   tx_valid         tx_data valid; transfer on tx_valid && tx_ready
//   done             high while idle
//   error            sticky error for the last request
module uart_command_serializer #(
    parameter int TIMEOUT   = 2000,
    parameter int MAX_BYTES = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*MAX_BYTES-1:0] input_data,
    input  logic [7:0]             input_data_size,
    input  logic                   ble_side,
    input  logic                   abort,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic                   done,
    output logic                   error
);

    localparam int          TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]  MAX_SIZE     = 9'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TERM0,
        TERM1
    } state_t;

    state_t                 state_q, state_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [7:0]             size_q, size_d;
    logic [7:0]             index_q, index_d;
    logic                   ble_q, ble_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   error_q, error_d;

    logic xfer;
    logic stall;
    logic size_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            size_q  <= '0;
            index_q <= '0;
            ble_q   <= 1'b0;
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            size_q  <= size_d;
            index_q <= index_d;
            ble_q   <= ble_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        size_d  = size_q;
        index_d = index_q;
        ble_d   = ble_q;
        timer_d = timer_q;
        error_d = error_q;

        // Outputs decode straight from registered state, so they are glitch
        // free and hold stable until the transfer edge.
        tx_valid = (state_q != IDLE);
        done     = (state_q == IDLE);
        error    = error_q;
        case (state_q)
            SEND:    tx_data = data_q[7:0];
            TERM0:   tx_data = ble_q ? 8'h0D : 8'hBE;
            TERM1:   tx_data = 8'hEF;
            default: tx_data = 8'h00;
        endcase

        xfer     = tx_valid && tx_ready;
        stall    = tx_valid && !tx_ready;
        size_bad = (input_data_size == 8'd0) || ({1'b0, input_data_size} > MAX_SIZE);

        case (state_q)
            IDLE: begin
                // abort takes priority over a coincident start
                if (start && !abort) begin
                    if (size_bad) begin
                        error_d = 1'b1;
                    end else begin
                        data_d  = input_data;
                        size_d  = input_data_size;
                        ble_d   = ble_side;
                        index_d = 8'd0;
                        error_d = 1'b0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    // The buffer shifts down so the next byte is always at [7:0].
                    data_d  = data_q >> 8;
                    index_d = index_q + 8'd1;
                    if (index_q == size_q - 8'd1) begin
                        state_d = TERM0;
                    end
                end
            end
            TERM0: begin
                if (xfer) begin
                    state_d = ble_q ? IDLE : TERM1;
                end
            end
            TERM1: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort and timeout both cut the send short; a byte accepted in the
        // abort cycle has already gone out and is not recalled.
        if (state_q != IDLE) begin
            if (abort) begin
                state_d = IDLE;
            end else if (stall && (timer_q == TIMEOUT_LAST)) begin
                state_d = IDLE;
                error_d = 1'b1;
            end
        end

        if ((state_d == IDLE) || xfer) begin
            timer_d = '0;
        end else if (stall) begin
            timer_d = timer_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_command_serializer.sv
// tb/tb_uart_command_serializer.sv - scoreboard bench for uart_command_serializer
module tb_uart_command_serializer;

    localparam int TO = 8;
    localparam int MB = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [8*MB-1:0] input_data;
    logic [7:0]      input_data_size;
    logic            ble_side;
    logic            abort;
    logic            tx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            done;
    logic            error;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;
    int         cyc;
    int         vcnt;

    uart_command_serializer #(.TIMEOUT(TO), .MAX_BYTES(MB)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .input_data      (input_data),
        .input_data_size (input_data_size),
        .ble_side        (ble_side),
        .abort           (abort),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected no byte", tx_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_byte", tx_data, sb_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) return;
            cycles++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_done: got done=0 after 400 cycles expected done=1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; ble_side = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        input_data = '0; input_data_size = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_done", done, 1);
        check("rst_error", error, 0);
        step();
        reset = 1'b0;

        // BLE send, ready tied high; inputs scrambled after start
        step();
        input_data = '0; input_data[23:0] = 24'h434241; input_data_size = 8'd3;
        ble_side = 1'b1; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h0D);
        step();
        start = 1'b0; input_data = '1; input_data_size = 8'd9; ble_side = 1'b0;
        wait_done(cyc);
        check("ble_done_low_cycles", cyc, 4);
        check("ble_error", error, 0);

        // Host send with alternating backpressure; held byte must not change
        step();
        input_data = '0; input_data[15:0] = 16'h2010; input_data_size = 8'd2;
        ble_side = 1'b0; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        begin
            logic       have_hold;
            logic [7:0] held;
            have_hold = 1'b0;
            held      = 8'h00;
            for (int i = 0; i < 20; i++) begin
                step();
                start    = 1'b0;
                tx_ready = ~tx_ready;
                @(negedge clk);
                if (done) break;
                if (have_hold) begin
                    check("bp_hold_data", tx_data, held);
                    have_hold = 1'b0;
                end
                if (tx_valid && !tx_ready) begin
                    held      = tx_data;
                    have_hold = 1'b1;
                end
            end
        end
        check("host_done", done, 1);
        check("host_error", error, 0);

        // Size bounds
        step();
        tx_ready = 1'b1; input_data_size = 8'd129; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("size129_error", error, 1);
        check("size129_done", done, 1);
        check("size129_valid", tx_valid, 0);
        step();
        input_data_size = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("size0_valid", tx_valid, 0);
        end
        check("size0_error", error, 1);

        step();
        for (int k = 0; k < 127; k++) begin
            input_data[8*k +: 8] = 8'(k);
            exp_q.push_back(8'(k));
        end
        input_data[8*127 +: 8] = 8'hFF;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h0D);
        input_data_size = 8'd128; ble_side = 1'b1; tx_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        check("size128_cycles", cyc, 129);
        check("size128_error", error, 0);

        // Timeout with ready held low
        step();
        input_data = '0; input_data[23:0] = 24'h030201; input_data_size = 8'd3;
        ble_side = 1'b0; tx_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
            vcnt++;
        end
        check("to_valid_cycles", vcnt, 8);
        check("to_error", error, 1);
        check("to_done", done, 1);
        step();
        input_data = '0; input_data[7:0] = 8'h55; input_data_size = 8'd1;
        ble_side = 1'b1; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h55); exp_q.push_back(8'h0D);
        step();
        start = 1'b0;
        @(negedge clk);
        check("to_error_cleared", error, 0);
        wait_done(cyc);
        check("to_resend_cycles", cyc, 1);

        // Abort while byte 2 of 5 is transferring
        step();
        input_data = '0; input_data[39:0] = 40'h0504030201; input_data_size = 8'd5;
        ble_side = 1'b1; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        @(negedge clk);
        check("abort_offer", tx_data, 8'h02);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", tx_valid, 0);
        check("abort_done", done, 1);
        check("abort_error", error, 0);

        // start + abort while busy -> idle
        step();
        input_data_size = 8'd4; tx_ready = 1'b0; start = 1'b1;
        step();
        abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("sa_valid", tx_valid, 0);
        check("sa_done", done, 1);
        @(negedge clk);
        check("sa_valid_stays", tx_valid, 0);

        // start while busy is ignored
        step();
        input_data = '0; input_data[15:0] = 16'hBBAA; input_data_size = 8'd2;
        ble_side = 1'b1; tx_ready = 1'b0; start = 1'b1;
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'h0D);
        step();
        input_data[7:0] = 8'hCC; input_data_size = 8'd1; ble_side = 1'b0;
        step();
        start = 1'b0; tx_ready = 1'b1;
        wait_done(cyc);
        check("busy_start_error", error, 0);

        // Reset in TERM1
        step();
        input_data = '0; input_data[7:0] = 8'h77; input_data_size = 8'd1;
        ble_side = 1'b0; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h77); exp_q.push_back(8'hBE);
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        check("term1_data", tx_data, 8'hEF);
        check("term1_valid", tx_valid, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_data", tx_data, 8'h00);
        check("mid_rst_done", done, 1);
        check("mid_rst_error", error, 0);
        step();
        input_data = '0; input_data[15:0] = 16'h3231; input_data_size = 8'd2;
        ble_side = 1'b1; tx_ready = 1'b1; start = 1'b1;
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h0D);
        step();
        start = 1'b0;
        wait_done(cyc);
        check("post_rst_cycles", cyc, 3);
        check("post_rst_error", error, 0);

        step();
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
